// File: rtl/multicycle_control.sv
// Main multicycle RV32I controller: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, plus ALU-function and immediate-format decode.
module multicycle_control #(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter int         ALU_W       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  output logic             PC_write_enable,
  output logic             adr_src,
  output logic             mem_write_signal,
  output logic             IR_write_enable,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic [ALU_W-1:0] alu_control,
  output logic             illegal_instr,
  output logic [3:0]       state_dbg
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10
  } state_t;

  typedef struct packed {
    logic             pc_write;
    logic             ir_write;
    logic             reg_write;
    logic             mem_write;
    logic             adr_src;
    logic             branch;
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [ALU_W-1:0] alu_control;
  } ctrl_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(5);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl_q;
  logic   op_legal;

  function automatic logic [ALU_W-1:0] alu_decode(input logic [2:0] f3,
                                                  input logic       is_r,
                                                  input logic       f7b5);
    logic [ALU_W-1:0] f;
    case (f3)
      3'b000:  f = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  f = ALU_SLT;
      3'b110:  f = ALU_OR;
      3'b111:  f = ALU_AND;
      default: f = ALU_ADD;
    endcase
    return f;
  endfunction

  function automatic ctrl_t ctrl_for(input state_t     s,
                                     input logic [2:0] f3,
                                     input logic       f7b5);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_write   = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      MEMREAD:  c.adr_src = 1'b1;
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      EXECUTER: begin
        c.alu_src_a   = 2'b10;
        c.alu_control = alu_decode(f3, 1'b1, f7b5);
      end
      EXECUTEI: begin
        c.alu_src_a   = 2'b10;
        c.alu_src_b   = 2'b01;
        c.alu_control = alu_decode(f3, 1'b0, f7b5);
      end
      ALUWB:    c.reg_write = 1'b1;
      JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_write  = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a   = 2'b10;
        c.alu_control = ALU_SUB;
        c.branch      = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    op_legal = 1'b1;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR: op_legal = 1'b1;
      default:                                 op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH: state_nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_R:         state_nxt = EXECUTER;
          OP_I:         state_nxt = EXECUTEI;
          OP_JAL:       state_nxt = JAL;
          OP_BR:        state_nxt = BRANCH;
          default:      state_nxt = FETCH;
        endcase
      end
      MEMADR:   state_nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_nxt = MEMWB;
      EXECUTER: state_nxt = ALUWB;
      EXECUTEI: state_nxt = ALUWB;
      JAL:      state_nxt = ALUWB;
      default:  state_nxt = FETCH;
    endcase
  end

  // Moore outputs are registered alongside the state by decoding the next state;
  // the instruction fields they use are stable from the end of FETCH onward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= state_t'(RESET_STATE);
      ctrl_q <= ctrl_for(state_t'(RESET_STATE), 3'b000, 1'b0);
    end else begin
      state  <= state_nxt;
      ctrl_q <= ctrl_for(state_nxt, funct3, funct7b5);
    end
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BR:   imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Enables are gated by reset directly so an asserted reset kills them at once.
  assign PC_write_enable  = ~reset & (ctrl_q.pc_write |
                                      (ctrl_q.branch & (zero ^ funct3[0])));
  assign IR_write_enable  = ~reset & ctrl_q.ir_write;
  assign reg_write        = ~reset & ctrl_q.reg_write;
  assign mem_write_signal = ~reset & ctrl_q.mem_write;
  assign adr_src          = ctrl_q.adr_src;
  assign result_src       = ctrl_q.result_src;
  assign alu_src_a        = ctrl_q.alu_src_a;
  assign alu_src_b        = ctrl_q.alu_src_b;
  assign alu_control      = ctrl_q.alu_control;
  assign illegal_instr    = ~reset & (state == DECODE) & ~op_legal;
  assign state_dbg        = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: each instruction pushes its
// per-cycle expected control word, which is popped and compared at negedges.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PC_write_enable, adr_src, mem_write_signal, IR_write_enable, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       illegal_instr;
  logic [3:0] state_dbg;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, rw, mw, adr;
    logic [1:0] rs, a, b, imm;
    logic [2:0] alu;
    logic       ill;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  multicycle_control #(.RESET_STATE(4'd0), .ALU_W(3)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .PC_write_enable(PC_write_enable), .adr_src(adr_src),
    .mem_write_signal(mem_write_signal), .IR_write_enable(IR_write_enable),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
    .illegal_instr(illegal_instr), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t mk(input logic [3:0] st, input logic pcw, input logic irw,
                              input logic rw, input logic mw, input logic adr,
                              input logic [1:0] rs, input logic [1:0] a,
                              input logic [1:0] b, input logic [1:0] imm,
                              input logic [2:0] alu, input logic ill);
    return {st, pcw, irw, rw, mw, adr, rs, a, b, imm, alu, ill};
  endfunction

  task automatic push(input exp_t e); exp_q.push_back(e); endtask

  task automatic p_reset(input logic [1:0] imm);
    push(mk(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0)); endtask
  task automatic p_fetch(input logic [1:0] imm);
    push(mk(4'd0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0)); endtask
  task automatic p_decode(input logic [1:0] imm, input logic ill);
    push(mk(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, ill)); endtask
  task automatic p_memadr(input logic [1:0] imm);
    push(mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 0)); endtask
  task automatic p_memread(input logic [1:0] imm);
    push(mk(4'd3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0)); endtask
  task automatic p_memwb(input logic [1:0] imm);
    push(mk(4'd4, 0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, imm, 3'b000, 0)); endtask
  task automatic p_memwrite(input logic [1:0] imm);
    push(mk(4'd5, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0)); endtask
  task automatic p_execr(input logic [2:0] alu);
    push(mk(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 0)); endtask
  task automatic p_execi(input logic [2:0] alu);
    push(mk(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 0)); endtask
  task automatic p_aluwb(input logic [1:0] imm);
    push(mk(4'd8, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0)); endtask
  task automatic p_jal();
    push(mk(4'd9, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0)); endtask
  task automatic p_branch(input logic pcw);
    push(mk(4'd10, pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0)); endtask

  task automatic check(input string tag);
    exp_t act, e;
    act = {state_dbg, PC_write_enable, IR_write_enable, reg_write, mem_write_signal,
           adr_src, result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr};
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: no expected entry, observed %h", tag, act);
    end else begin
      e = exp_q.pop_front();
      assert (act === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, act, e);
      end
    end
  endtask

  task automatic run(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s c%0d", tag, i + 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set(input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
  endtask

  initial begin
    reset = 1'b1;
    set(7'b0000011, 3'b010, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 3; i++) begin
      p_reset(2'b00);
      @(negedge clk);
      check("reset");
    end
    @(posedge clk);
    #1 reset = 1'b0;

    // lw: 5 cycles
    p_fetch(2'b00); p_decode(2'b00, 0); p_memadr(2'b00); p_memread(2'b00); p_memwb(2'b00);
    run("lw", 5);

    // sw: 4 cycles
    set(7'b0100011, 3'b010, 1'b0, 1'b0);
    p_fetch(2'b01); p_decode(2'b01, 0); p_memadr(2'b01); p_memwrite(2'b01);
    run("sw", 4);

    set(7'b0110011, 3'b000, 1'b1, 1'b0);
    p_fetch(2'b00); p_decode(2'b00, 0); p_execr(3'b001); p_aluwb(2'b00);
    run("sub", 4);

    set(7'b0010011, 3'b000, 1'b1, 1'b0);
    p_fetch(2'b00); p_decode(2'b00, 0); p_execi(3'b000); p_aluwb(2'b00);
    run("addi_b30", 4);

    set(7'b0110011, 3'b111, 1'b0, 1'b0);
    p_fetch(2'b00); p_decode(2'b00, 0); p_execr(3'b010); p_aluwb(2'b00);
    run("and", 4);

    set(7'b0010011, 3'b110, 1'b0, 1'b0);
    p_fetch(2'b00); p_decode(2'b00, 0); p_execi(3'b011); p_aluwb(2'b00);
    run("ori", 4);

    set(7'b0110011, 3'b010, 1'b0, 1'b0);
    p_fetch(2'b00); p_decode(2'b00, 0); p_execr(3'b101); p_aluwb(2'b00);
    run("slt", 4);

    set(7'b1100011, 3'b000, 1'b0, 1'b1);
    p_fetch(2'b10); p_decode(2'b10, 0); p_branch(1'b1);
    run("beq_taken", 3);

    set(7'b1100011, 3'b000, 1'b0, 1'b0);
    p_fetch(2'b10); p_decode(2'b10, 0); p_branch(1'b0);
    run("beq_not", 3);

    set(7'b1100011, 3'b001, 1'b0, 1'b1);
    p_fetch(2'b10); p_decode(2'b10, 0); p_branch(1'b0);
    run("bne_not", 3);

    set(7'b1100011, 3'b001, 1'b0, 1'b0);
    p_fetch(2'b10); p_decode(2'b10, 0); p_branch(1'b1);
    run("bne_taken", 3);

    set(7'b1101111, 3'b000, 1'b0, 1'b0);
    p_fetch(2'b11); p_decode(2'b11, 0); p_jal(); p_aluwb(2'b11);
    run("jal", 4);

    set(7'b1111111, 3'b000, 1'b0, 1'b0);
    p_fetch(2'b00); p_decode(2'b00, 1);
    run("illegal", 2);

    // sw interrupted by reset while in MEMWRITE
    set(7'b0100011, 3'b010, 1'b0, 1'b0);
    p_fetch(2'b01); p_decode(2'b01, 0); p_memadr(2'b01);
    run("sw_abort", 3);
    p_memwrite(2'b01);
    @(negedge clk);
    check("memwrite_pre_reset");
    #2 reset = 1'b1;
    #1;
    p_reset(2'b01);
    check("async_reset_memwrite");
    @(posedge clk);
    #1 reset = 1'b0;

    set(7'b0110011, 3'b000, 1'b0, 1'b0);
    p_fetch(2'b00); p_decode(2'b00, 0); p_execr(3'b000); p_aluwb(2'b00);
    run("add_after_reset", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
